// File: rtl/instr_loader.sv
// Purpose: packs a byte stream MSB-first into words and writes them to a fixed instruction region.
// Latency: the word strobe appears the cycle after its final byte is accepted; the next byte is taken one cycle later.
// Backpressure: byte_ready drops during the write cycle and outside a load; unaccepted bytes are left on the input.
module instr_loader #(
  parameter int                         DATA_WIDTH        = 8,
  parameter int                         ADDRESS_WIDTH     = 32,
  parameter int                         INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR         = 32'hBFC00000,
  parameter int                         REGION_BYTES      = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          byte_valid,
  input  logic [DATA_WIDTH-1:0]         byte_data,
  input  logic                          byte_last,
  output logic                          byte_ready,
  output logic                          wr_en,
  output logic [ADDRESS_WIDTH-1:0]      wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0]  wr_data,
  output logic                          busy,
  output logic                          done,
  output logic [10:0]                   word_count
);

  localparam int BPW        = INSTRUCTION_WIDTH / DATA_WIDTH;
  localparam int IDX_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WORD_BYTES = INSTRUCTION_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR =
    BASE_ADDR + ADDRESS_WIDTH'(REGION_BYTES - WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [ADDRESS_WIDTH-1:0]       word_addr;
  logic [IDX_W-1:0]               byte_idx;
  logic [INSTRUCTION_WIDTH-1:0]   word_buf;
  logic [INSTRUCTION_WIDTH-1:0]   merged;
  logic                           last_q;
  logic                           load_accept;
  logic                           word_end;
  logic                           region_end;

  // Accept qualifiers are derived from the state register, not byte_ready, to keep the logic acyclic.
  assign load_accept = (state == LOAD) && byte_valid;
  assign word_end    = byte_last || (byte_idx == LAST_IDX);
  assign region_end  = (word_addr == LAST_ADDR);

  // State register; reset forces IDLE so all state-decoded outputs drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the state-derived handshake/status outputs.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && word_end) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        busy      = 1'b1;
        state_nxt = (last_q || region_end) ? DONE : LOAD;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drop the incoming byte into its lane; lane 0 is the most significant so stream order matches memory order.
  always_comb begin
    merged = word_buf;
    for (int k = 0; k < BPW; k++) begin
      if (byte_idx == IDX_W'(k)) begin
        merged[(BPW-1-k)*DATA_WIDTH +: DATA_WIDTH] = byte_data;
      end
    end
  end

  // Datapath: byte assembly, write-port capture, address and word counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_addr  <= BASE_ADDR;
      byte_idx   <= '0;
      word_buf   <= '0;
      last_q     <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            word_addr  <= BASE_ADDR;
            word_count <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            last_q     <= 1'b0;
          end
        end
        LOAD: begin
          if (load_accept) begin
            if (word_end) begin
              // Capture here so wr_addr/wr_data are valid throughout WRITE and hold afterwards.
              wr_addr <= word_addr;
              wr_data <= merged;
              last_q  <= byte_last;
            end else begin
              word_buf <= merged;
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          word_count <= word_count + 11'd1;
          // Parking on the last word keeps the pointer inside the region; the FSM ends the load anyway.
          if (!region_end) word_addr <= word_addr + ADDRESS_WIDTH'(WORD_BYTES);
          byte_idx   <= '0;
          word_buf   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
